// File: rtl/upower_xo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | upower_xo_pkg - shared types, opcodes and decoder for the X/XO core  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package upower_xo_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    AND   = 4'd0,
    OR    = 4'd1,
    XOR   = 4'd2,
    NAND  = 4'd3,
    NOR   = 4'd4,
    EXTSW = 4'd5,
    ADD   = 4'd6,
    SUBF  = 4'd7,
    NEG   = 4'd8
  } alu_op_t;

  localparam logic [5:0] PO_X      = 6'd31;
  localparam logic [9:0] XOX_AND   = 10'd28;
  localparam logic [9:0] XOX_OR    = 10'd444;
  localparam logic [9:0] XOX_XOR   = 10'd316;
  localparam logic [9:0] XOX_NAND  = 10'd476;
  localparam logic [9:0] XOX_NOR   = 10'd124;
  localparam logic [9:0] XOX_EXTSW = 10'd986;
  localparam logic [8:0] XOXO_ADD  = 9'd266;
  localparam logic [8:0] XOXO_SUBF = 9'd40;
  localparam logic [8:0] XOXO_NEG  = 9'd104;

  typedef struct packed {
    logic    legal;
    logic    is_xo;
    alu_op_t op;
  } decode_t;

  // XO opcodes are matched on the 9-bit field first so that oe=1 variants decode too.
  function automatic decode_t decode_insn(input logic [31:0] insn, input logic is_64);
    decode_t d;
    d.legal = 1'b1;
    d.is_xo = 1'b0;
    d.op    = AND;
    if (insn[31:26] != PO_X) begin
      d.legal = 1'b0;
    end else begin
      case (insn[9:1])
        XOXO_ADD:  begin d.is_xo = 1'b1; d.op = ADD;  end
        XOXO_SUBF: begin d.is_xo = 1'b1; d.op = SUBF; end
        XOXO_NEG:  begin d.is_xo = 1'b1; d.op = NEG;  end
        default: begin
          case (insn[10:1])
            XOX_AND:   d.op = AND;
            XOX_OR:    d.op = OR;
            XOX_XOR:   d.op = XOR;
            XOX_NAND:  d.op = NAND;
            XOX_NOR:   d.op = NOR;
            XOX_EXTSW: begin d.op = EXTSW; d.legal = is_64; end
            default:   d.legal = 1'b0;
          endcase
        end
      endcase
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/upower_xo_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | upower_xo_alu - combinational logical/arithmetic unit with overflow  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module upower_xo_alu import upower_xo_pkg::*; #(
  parameter int XLEN = 64
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            ov
);

  always_comb begin
    res = '0;
    ov  = 1'b0;
    case (op)
      AND:   res = a & b;
      OR:    res = a | b;
      XOR:   res = a ^ b;
      NAND:  res = ~(a & b);
      NOR:   res = ~(a | b);
      EXTSW: res = XLEN'($signed(a[31:0]));
      ADD: begin
        res = a + b;
        ov  = (a[XLEN-1] == b[XLEN-1]) && (res[XLEN-1] != a[XLEN-1]);
      end
      SUBF: begin
        res = b - a;
        ov  = (b[XLEN-1] != a[XLEN-1]) && (res[XLEN-1] != b[XLEN-1]);
      end
      NEG: begin
        res = '0 - a;
        ov  = a[XLEN-1] && (a[XLEN-2:0] == '0);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/upower_xo_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | upower_xo_multicycle - 4-state X/XO core; UPOWER_XO_OV_EN adds XER OV |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module upower_xo_multicycle import upower_xo_pkg::*; #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int PC_W  = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halt,
  output logic [3:0]      cr0,
  output logic            xer_so,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  localparam int RIDX = $clog2(NREGS);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              imem_req_q, imem_req_d;
  logic              busy_q, busy_d;
  logic              halt_q, halt_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic              ov_q, ov_d;
  alu_op_t           op_q, op_d;
  logic              is_xo_q, is_xo_d;
  logic [RIDX-1:0]   dest_q, dest_d;
  logic [3:0]        cr0_q, cr0_d;
  logic              xer_so_q, xer_so_d, xer_ov_q, xer_ov_d;
  logic              reg_we;
  logic [XLEN-1:0]   regs_q [NREGS];

  decode_t           dec;
  logic [RIDX-1:0]   rs_idx, ra_idx, rb_idx;
  logic [XLEN-1:0]   alu_res;
  logic              alu_ov;

  assign dec    = decode_insn(ir_q, XLEN == 64);
  assign rs_idx = ir_q[21 +: RIDX];
  assign ra_idx = ir_q[16 +: RIDX];
  assign rb_idx = ir_q[11 +: RIDX];

  upower_xo_alu #(.XLEN(XLEN)) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (alu_res),
    .ov  (alu_ov)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req_d = imem_req_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    ov_d       = ov_q;
    op_d       = op_q;
    is_xo_d    = is_xo_q;
    dest_d     = dest_q;
    cr0_d      = cr0_q;
    xer_so_d   = xer_so_q;
    xer_ov_d   = xer_ov_q;
    reg_we     = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
          ir_d       = imem_data;
          imem_req_d = 1'b0;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        if (!dec.legal) begin
          state_d = HALT;
        end else begin
          op_d    = dec.op;
          is_xo_d = dec.is_xo;
          a_d     = dec.is_xo ? regs_q[ra_idx] : regs_q[rs_idx];
          b_d     = regs_q[rb_idx];
          dest_d  = dec.is_xo ? rs_idx : ra_idx;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        res_d   = alu_res;
        ov_d    = alu_ov;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        reg_we = 1'b1;
`ifdef UPOWER_XO_OV_EN
        if (is_xo_q && ir_q[10]) begin
          xer_ov_d = ov_q;
          xer_so_d = xer_so_q | ov_q;
        end
`endif
        // CR0.SO must see the summary overflow including this instruction.
        if (ir_q[0]) begin
          cr0_d = {res_q[XLEN-1], ~res_q[XLEN-1] & (|res_q), res_q == '0, xer_so_d};
        end
        pc_d       = pc_q + PC_W'(1);
        imem_req_d = 1'b1;
        state_d    = FETCH;
      end
      HALT: begin
        imem_req_d = 1'b0;
      end
      default: begin
        imem_req_d = 1'b0;
        state_d    = HALT;
      end
    endcase
    halt_d = (state_d == HALT);
    busy_d = (state_d != HALT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      imem_req_q <= 1'b0;
      busy_q     <= 1'b1;
      halt_q     <= 1'b0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      ov_q       <= 1'b0;
      op_q       <= AND;
      is_xo_q    <= 1'b0;
      dest_q     <= '0;
      cr0_q      <= '0;
      xer_so_q   <= 1'b0;
      xer_ov_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imem_req_q <= imem_req_d;
      busy_q     <= busy_d;
      halt_q     <= halt_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      ov_q       <= ov_d;
      op_q       <= op_d;
      is_xo_q    <= is_xo_d;
      dest_q     <= dest_d;
      cr0_q      <= cr0_d;
      xer_so_q   <= xer_so_d;
      xer_ov_q   <= xer_ov_d;
      if (reg_we) regs_q[dest_q] <= res_q;
    end
  end

`ifdef UPOWER_XO_OV_EN
  logic unused_sel;
  assign unused_sel = ^{dbg_sel, ir_q, xer_ov_q};
`else
  logic unused_sel;
  assign unused_sel = ^{dbg_sel, ir_q, ov_q, is_xo_q, xer_ov_q};
`endif

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halt      = halt_q;
  assign cr0       = cr0_q;
  assign xer_so    = xer_so_q;
  assign dbg_data  = regs_q[dbg_sel[RIDX-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_upower_xo_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_upower_xo_multicycle - randomized bench with ISA-level model      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_upower_xo_multicycle;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic        busy;
  logic        halt;
  logic [3:0]  cr0;
  logic        xer_so;
  logic [4:0]  dbg_sel;
  logic [63:0] dbg_data;

  upower_xo_multicycle #(.XLEN(64), .NREGS(32), .PC_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .pc        (pc),
    .busy      (busy),
    .halt      (halt),
    .cr0       (cr0),
    .xer_so    (xer_so),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_regs [32];
  logic [31:0] m_pc;
  logic [3:0]  m_cr0;
  logic        m_so, m_ov;
  int          m_dest;

`ifdef UPOWER_XO_OV_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rd(input int idx, output logic [63:0] v);
    dbg_sel = 5'(idx);
    #1;
    v = dbg_data;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0; m_cr0 = '0; m_so = 1'b0; m_ov = 1'b0; m_dest = 0;
  endfunction

  function automatic logic signed [65:0] sx(input logic [63:0] v);
    return $signed({{2{v[63]}}, v});
  endfunction

  // ISA-level reference: one call retires one instruction or reports it illegal.
  function automatic bit model_exec(input logic [31:0] insn);
    int po = int'(insn[31:26]);
    int x9 = int'(insn[9:1]);
    int x10 = int'(insn[10:1]);
    int f1 = int'(insn[25:21]);
    int f2 = int'(insn[20:16]);
    int f3 = int'(insn[15:11]);
    logic [63:0] a, b, r;
    logic signed [65:0] wide;
    bit arith, ovf;
    if (po != 31) return 1'b0;
    arith = (x9 == 266) || (x9 == 40) || (x9 == 104);
    ovf = 1'b0;
    if (arith) begin
      a = m_regs[f2];
      b = m_regs[f3];
      if (x9 == 266)     wide = sx(a) + sx(b);
      else if (x9 == 40) wide = sx(b) - sx(a);
      else               wide = 66'sd0 - sx(a);
      r = wide[63:0];
      ovf = (wide != sx(r));
      m_dest = f1;
    end else begin
      a = m_regs[f1];
      b = m_regs[f3];
      case (x10)
        28:  r = a & b;
        444: r = a | b;
        316: r = a ^ b;
        476: r = ~(a & b);
        124: r = ~(a | b);
        986: r = {{32{a[31]}}, a[31:0]};
        default: return 1'b0;
      endcase
      m_dest = f2;
    end
    m_regs[m_dest] = r;
    if (OV_EN && arith && insn[10]) begin
      m_ov = ovf;
      m_so = m_so | ovf;
    end
    if (insn[0]) m_cr0 = {$signed(r) < 0, $signed(r) > 0, r == 64'd0, m_so};
    m_pc = m_pc + 32'd1;
    return 1'b1;
  endfunction

  function automatic logic [31:0] enc_x(input int xo, input int rs, input int ra, input int rb, input int rc);
    return {6'd31, 5'(rs), 5'(ra), 5'(rb), 10'(xo), 1'(rc)};
  endfunction

  function automatic logic [31:0] enc_xo(input int xo, input int rt, input int ra, input int rb, input int oe, input int rc);
    return {6'd31, 5'(rt), 5'(ra), 5'(rb), 1'(oe), 9'(xo), 1'(rc)};
  endfunction

  // Serves one fetch with `waits` idle cycles, then checks retirement against the model.
  task automatic run_insn(input logic [31:0] insn, input int waits);
    int cyc;
    bit legal;
    logic [63:0] v;
    int probe;
    cyc = 0;
    while (!imem_req && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    if (!imem_req) begin
      chk("req_timeout", 64'(imem_req), 64'd1);
      return;
    end
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    for (int w = 0; w < waits; w++) begin
      imem_data = $urandom;
      @(negedge clock);
      chk("req_hold", 64'(imem_req), 64'd1);
      chk("addr_hold", 64'(imem_addr), 64'(m_pc));
    end
    imem_ack  = 1'b1;
    imem_data = insn;
    cyc = waits;
    @(negedge clock);
    cyc++;
    while (!imem_req && !halt && cyc < waits + 12) begin
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      @(negedge clock);
      cyc++;
    end
    imem_ack = 1'b0;
    legal = model_exec(insn);
    if (legal) begin
      chk("latency", 64'(cyc), 64'(4 + waits));
      chk("pc", 64'(pc), 64'(m_pc));
      chk("cr0", 64'(cr0), 64'(m_cr0));
      chk("xer_so", 64'(xer_so), 64'(m_so));
      chk("halt_low", 64'(halt), 64'd0);
      rd(m_dest, v);
      chk("dest_reg", v, m_regs[m_dest]);
      probe = $urandom_range(0, 31);
      rd(probe, v);
      chk("probe_reg", v, m_regs[probe]);
    end else begin
      chk("halt_high", 64'(halt), 64'd1);
      chk("busy_low", 64'(busy), 64'd0);
      chk("pc_hold", 64'(pc), 64'(m_pc));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int x_ops [6]  = '{28, 444, 316, 476, 124, 986};
  int xo_ops [3] = '{266, 40, 104};

  initial begin
    logic [63:0] v;
    logic [31:0] insn;
    int k;
    reset_n = 1'b0; imem_ack = 1'b0; imem_data = '0; dbg_sel = '0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_cr0", 64'(cr0), 64'd0);
    chk("rst_so", 64'(xer_so), 64'd0);
    rd(31, v);
    chk("rst_r31", v, 64'd0);
    reset_n = 1'b1;
    chk("req_before_edge", 64'(imem_req), 64'd0);
    @(negedge clock);
    chk("req_rise", 64'(imem_req), 64'd1);

    // Constants built from r0: -1, 1, 2, 4, then r1=5, r2=7.
    run_insn(enc_x(124, 0, 10, 0, 0), 0);
    run_insn(enc_xo(104, 11, 10, 0, 0, 0), 0);
    run_insn(enc_xo(266, 12, 11, 11, 0, 0), 0);
    run_insn(enc_xo(266, 13, 12, 12, 0, 0), 1);
    run_insn(enc_xo(266, 1, 13, 11, 0, 0), 0);
    run_insn(enc_xo(266, 14, 12, 1, 0, 0), 0);
    run_insn(enc_x(444, 14, 2, 14, 0), 0);

    run_insn(enc_xo(266, 3, 1, 2, 0, 1), 0);
    rd(3, v);
    chk("add_r3", v, 64'd12);
    chk("add_cr0", 64'(cr0), 64'b0100);

    run_insn(enc_x(444, 14, 1, 14, 0), 0);
    run_insn(enc_xo(266, 2, 13, 11, 0, 0), 0);
    run_insn(enc_xo(40, 4, 1, 2, 0, 1), 0);
    rd(4, v);
    chk("subf_r4", v, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("subf_cr0", 64'(cr0), 64'b1000);

    run_insn(enc_x(316, 1, 8, 2, 1), 3);

    run_insn(enc_x(444, 11, 20, 11, 0), 0);
    for (int i = 0; i < 63; i++) run_insn(enc_xo(266, 20, 20, 20, 0, 0), 0);
    run_insn(enc_x(124, 20, 6, 20, 0), 0);
    rd(6, v);
    chk("r6_maxpos", v, 64'h7FFF_FFFF_FFFF_FFFF);
    run_insn(enc_xo(266, 5, 6, 6, 1, 0), 0);
    rd(5, v);
    chk("addo_r5", v, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("addo_so", 64'(xer_so), 64'(OV_EN));
    run_insn(enc_xo(266, 9, 1, 2, 0, 1), 0);
    chk("add_dot_so", 64'(cr0[0]), 64'(OV_EN));
    run_insn(enc_xo(104, 15, 20, 0, 1, 1), 0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 8);
      if (k < 6)
        insn = enc_x(x_ops[k], $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 1));
      else
        insn = enc_xo(xo_ops[k-6], $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1));
      run_insn(insn, $urandom_range(0, 2));
    end
    for (int i = 0; i < 32; i++) begin
      rd(i, v);
      chk("sweep_reg", v, m_regs[i]);
    end

    // Abort an xor while it is in EXECUTE.
    while (!imem_req) @(negedge clock);
    imem_ack = 1'b1;
    imem_data = enc_x(316, 1, 7, 2, 1);
    @(negedge clock);
    imem_ack = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("abort_pc", 64'(pc), 64'd0);
    chk("abort_req", 64'(imem_req), 64'd0);
    rd(7, v);
    chk("abort_r7", v, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_refetch", 64'(imem_req), 64'd1);
    chk("abort_addr", 64'(imem_addr), 64'd0);
    run_insn(enc_x(124, 0, 16, 0, 1), 0);

    run_insn(32'h0000_0000, 0);
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("halt_req_low", 64'(imem_req), 64'd0);
      chk("halt_stays", 64'(halt), 64'd1);
    end
    imem_ack = 1'b0;
    chk("halt_pc", 64'(pc), 64'(m_pc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
